batrider_gp9001_bus: RTL
========================

Name: batrider_gp9001_bus

Overview:
- CPU-side bus bridge directly upstream of batrider_video.
- Converts 68000 data-bus accesses to the GP9001 window and the object-bank window into the one-hot GP9001_OP_* strobes, GP9001CS, GP9001DIN and GP9001_OBJECTBANK_SLOT that batrider_video consumes.
- Returns read data and a DTACK-style acknowledge to the CPU once GP9001ACK arrives.
- Runs on CLK (CPU domain).

Parameters:
- TIMEOUT, 255: CLK cycles to wait for GP9001ACK before forcing completion. Used only with GP9001_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- CPU_GP_CS  in  1  CPU access to the GP9001 window; held for the whole bus cycle
- CPU_OBJ_CS  in  1  CPU access to the object-bank window
- CPU_RNW  in  1  1=read, 0=write
- CPU_ADDR  in  3  word address A[3:1]
- CPU_DIN  in  16  CPU write data
- CPU_DOUT  out  16  read data to CPU
- CPU_DTACK  out  1  access complete
- GP9001CS  out  1  request to GCU
- GP9001ACK  in  1  GCU completion
- GP9001DIN  out  16  write data to GCU
- GP9001DOUT  in  16  GCU read data
- GP9001_OP_SELECT_REG, GP9001_OP_WRITE_REG, GP9001_OP_WRITE_RAM, GP9001_OP_READ_RAM_H, GP9001_OP_READ_RAM_L, GP9001_OP_SET_RAM_PTR, GP9001_OP_OBJECTBANK_WR  out  1 each  op select, one-hot
- GP9001_OBJECTBANK_SLOT  out  3  object-bank slot
- BUS_ERR  out  1  sticky timeout flag; tied 0 when GP9001_TIMEOUT_EN is off

Behaviour:
- Clock/reset: single clock CLK; reset RESET is synchronous, active-high.
- Reset values: all outputs 0, state IDLE.
- Reset mid-operation: all strobes drop on the next edge; any pending CPU access gets no DTACK.
- Decode, GP9001 window (write ops):
  - A=0 -> SET_RAM_PTR
  - A=2 or 3 -> WRITE_RAM
  - A=4 -> SELECT_REG
  - A=6 -> WRITE_REG
- Decode, GP9001 window (read ops):
  - A=2 -> READ_RAM_H
  - A=3 -> READ_RAM_L
- Object-bank window: write -> OBJECTBANK_WR with SLOT=A.
- Unmapped accesses (other address/direction combinations): no GCU request; DTACK one cycle after decode; read data 0xFFFF.
- If CPU_GP_CS and CPU_OBJ_CS are both high, the GP9001 window wins.
- State machine:
  - IDLE: on a CS rising level (CS high and no access yet served for it), latch addr/rnw/data and compute the op -> ISSUE, or -> DONE if unmapped.
  - ISSUE: drive GP9001CS=1, exactly one OP strobe, GP9001DIN, SLOT -> WAIT.
  - WAIT: hold all outputs stable. When GP9001ACK=1, drop GP9001CS and the OP strobe in the same edge, latch GP9001DOUT into CPU_DOUT on reads -> DONE.
  - DONE: CPU_DTACK=1 until both CS inputs are low, then DTACK=0 -> IDLE.
- A CS held high across DONE never re-triggers, so there is exactly one GCU op per CPU bus cycle.
- Latency: GP9001CS rises 2 cycles after CS; DTACK rises 1 cycle after the ACK edge is sampled.
- ACK while not in WAIT: ignored.
- CPU_DOUT holds its last value between reads; 0 after reset.

Optional Feature:
- Macro: GP9001_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in WAIT.
  - On reaching TIMEOUT with no ACK: drop GP9001CS and the strobes, CPU_DOUT=0xFFFF on reads, set BUS_ERR (sticky until RESET), go to DONE.
  - ACK arriving in the same cycle as the timeout is treated as a normal ACK: data latched, BUS_ERR not set.
- Undefined: no counter; WAIT lasts indefinitely; BUS_ERR=0.

Test Plan:
- Write CS, A=0, DIN=0x1234, ACK 3 cycles after GP9001CS:
  - SET_RAM_PTR=1 and GP9001DIN=0x1234 until ACK.
  - DTACK 1 cycle after ACK.
  - One op only, with CS held 10 more cycles.
- Read A=3, GP9001DOUT=0xBEEF at ACK -> READ_RAM_L strobe; CPU_DOUT=0xBEEF with DTACK.
- Object write A=5, DIN=0x0012 -> OBJECTBANK_WR=1, SLOT=5, GP9001DIN=0x0012.
- Read A=6 (unmapped) -> no GP9001CS; DTACK=1; CPU_DOUT=0xFFFF.
- RESET asserted during WAIT -> next edge all strobes and GP9001CS are 0; no DTACK.
- With GP9001_TIMEOUT_EN, no ACK -> forced DONE after 255 cycles; BUS_ERR=1; read returns 0xFFFF.

Source files
------------

// File: rtl/batrider_gp9001_bus.sv
//============================================================================
// Module  : batrider_gp9001_bus
// Brief   : 68000 bus bridge that turns GP9001/object-bank window accesses into
//           one-hot GCU op strobes and returns DTACK. Optional GCU-ACK
//           watchdog is enabled with the GP9001_TIMEOUT_EN macro.
// Rev     : 1.0
//============================================================================
`default_nettype none

module batrider_gp9001_bus #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CPU_GP_CS,
  input  logic        CPU_OBJ_CS,
  input  logic        CPU_RNW,
  input  logic [2:0]  CPU_ADDR,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  output logic        CPU_DTACK,
  output logic        GP9001CS,
  input  logic        GP9001ACK,
  output logic [15:0] GP9001DIN,
  input  logic [15:0] GP9001DOUT,
  output logic        GP9001_OP_SELECT_REG,
  output logic        GP9001_OP_WRITE_REG,
  output logic        GP9001_OP_WRITE_RAM,
  output logic        GP9001_OP_READ_RAM_H,
  output logic        GP9001_OP_READ_RAM_L,
  output logic        GP9001_OP_SET_RAM_PTR,
  output logic        GP9001_OP_OBJECTBANK_WR,
  output logic [2:0]  GP9001_OBJECTBANK_SLOT,
  output logic        BUS_ERR
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Op vector bit order: {OBJ_WR, SET_PTR, RD_L, RD_H, WR_RAM, WR_REG, SEL_REG}
  logic [1:0]  r_state, w_next;
  logic [6:0]  w_dec, r_op, w_op_out;
  logic [15:0] r_din, r_dout;
  logic [2:0]  r_slot;
  logic        r_rnw, r_armed, r_buserr;
  logic        w_any_cs, w_obj_sel, w_start, w_timeout, w_gpcs, w_dtack;

  assign w_any_cs  = CPU_GP_CS | CPU_OBJ_CS;
  assign w_obj_sel = CPU_OBJ_CS & ~CPU_GP_CS;
  // r_armed blocks a CS that was already high through reset or DONE from re-triggering
  assign w_start   = (r_state == S_IDLE) && w_any_cs && r_armed;

  always_comb begin
    w_dec = 7'd0;
    if (CPU_GP_CS) begin
      if (!CPU_RNW) begin
        case (CPU_ADDR)
          3'd0:       w_dec = 7'b0100000;
          3'd2, 3'd3: w_dec = 7'b0000100;
          3'd4:       w_dec = 7'b0000001;
          3'd6:       w_dec = 7'b0000010;
          default:    w_dec = 7'd0;
        endcase
      end else begin
        case (CPU_ADDR)
          3'd2:    w_dec = 7'b0001000;
          3'd3:    w_dec = 7'b0010000;
          default: w_dec = 7'd0;
        endcase
      end
    end else if (CPU_OBJ_CS && !CPU_RNW) begin
      w_dec = 7'b1000000;
    end
  end

`ifdef GP9001_TIMEOUT_EN
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RESET || r_state != S_WAIT) r_cnt <= 8'd0;
    else                            r_cnt <= r_cnt + 8'd1;
  end

  assign w_timeout = (r_state == S_WAIT) && (r_cnt == c_TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = (|w_dec) ? S_ISSUE : S_DONE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (GP9001ACK || w_timeout) w_next = S_DONE;
      S_DONE:  if (!w_any_cs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_gpcs   = (r_state == S_WAIT);
    w_dtack  = (r_state == S_DONE);
    w_op_out = w_gpcs ? r_op : 7'd0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_op     <= 7'd0;
      r_din    <= 16'd0;
      r_slot   <= 3'd0;
      r_rnw    <= 1'b0;
      r_dout   <= 16'd0;
      r_armed  <= 1'b0;
      r_buserr <= 1'b0;
    end else begin
      if (!w_any_cs)   r_armed <= 1'b1;
      else if (w_start) r_armed <= 1'b0;
      if (w_start) begin
        r_op   <= w_dec;
        r_rnw  <= CPU_RNW;
        r_din  <= CPU_DIN;
        r_slot <= w_obj_sel ? CPU_ADDR : 3'd0;
        if (!(|w_dec) && CPU_RNW) r_dout <= 16'hFFFF;
      end
      if (r_state == S_WAIT) begin
        if (GP9001ACK) begin
          if (r_rnw) r_dout <= GP9001DOUT;
        end else if (w_timeout) begin
          if (r_rnw) r_dout <= 16'hFFFF;
          r_buserr <= 1'b1;
        end
      end
    end
  end

  assign CPU_DOUT                = r_dout;
  assign CPU_DTACK               = w_dtack;
  assign GP9001CS                = w_gpcs;
  assign GP9001DIN               = r_din;
  assign GP9001_OBJECTBANK_SLOT  = r_slot;
  assign BUS_ERR                 = r_buserr;
  assign GP9001_OP_SELECT_REG    = w_op_out[0];
  assign GP9001_OP_WRITE_REG     = w_op_out[1];
  assign GP9001_OP_WRITE_RAM     = w_op_out[2];
  assign GP9001_OP_READ_RAM_H    = w_op_out[3];
  assign GP9001_OP_READ_RAM_L    = w_op_out[4];
  assign GP9001_OP_SET_RAM_PTR   = w_op_out[5];
  assign GP9001_OP_OBJECTBANK_WR = w_op_out[6];

endmodule

`default_nettype wire
